// File: rtl/cadc_pkg.sv
// Shared constants and types for the cadc_enc redundant-digit encoder.
// The optional per-sample clamp flag is enabled with CADC_ENC_OVR_EN.
package cadc_pkg;

    localparam int CADC_NSTAGE = 7;

    typedef logic [1:0]        dig_t;
    typedef logic signed [8:0] res_t;

    localparam dig_t DIG_P1 = 2'b01;
    localparam dig_t DIG_M1 = 2'b11;
    localparam dig_t DIG_Z  = 2'b00;

    localparam logic signed [7:0] RAMP_MIN      = -8'sd127;
    localparam logic signed [7:0] RAMP_MAX      = 8'sd127;
    localparam logic signed [7:0] SAMPLE_NEG_FS = 8'sh80;

    function automatic int stage_weight(input int i);
        return 32'sd1 << (32'sd6 - i);
    endfunction

endpackage

// File: rtl/cadc_enc_stage.sv
// One redundant-digit stage: compares twice the residue against its weight,
// registers the digit, the reduced residue and (with CADC_ENC_OVR_EN) the clamp flag.
module cadc_enc_stage
    import cadc_pkg::*;
#(
    parameter int W = 64
) (
    input  logic clk,
    input  logic rstn,
    input  res_t i_res,
`ifdef CADC_ENC_OVR_EN
    input  logic i_flag,
    output logic o_flag,
`endif
    output dig_t o_dig,
    output res_t o_res
);

    localparam logic signed [9:0] W_S = 10'(W);
    localparam res_t              W_R = res_t'(W);

    logic signed [9:0] w_twice;
    dig_t              w_dig;
    res_t              w_res_nxt;
    dig_t              r_dig;
    res_t              r_res;

    assign w_twice = {i_res, 1'b0};

    // Digit selection: strictly-inside band keeps the residue unchanged.
    always_comb begin
        w_dig     = DIG_Z;
        w_res_nxt = i_res;
        if (w_twice >= W_S) begin
            w_dig     = DIG_P1;
            w_res_nxt = i_res - W_R;
        end else if (w_twice <= -W_S) begin
            w_dig     = DIG_M1;
            w_res_nxt = i_res + W_R;
        end else begin
            w_dig     = DIG_Z;
            w_res_nxt = i_res;
        end
    end

    // Digit and residue registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_dig <= DIG_Z;
            r_res <= 9'sd0;
        end else begin
            r_dig <= w_dig;
            r_res <= w_res_nxt;
        end
    end

`ifdef CADC_ENC_OVR_EN
    logic r_flag;

    // Clamp flag travels alongside the residue of the same sample.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_flag <= 1'b0;
        end else begin
            r_flag <= i_flag;
        end
    end

    assign o_flag = r_flag;
`endif

    assign o_dig = r_dig;
    assign o_res = r_res;

endmodule

// File: rtl/cadc_enc.sv
// cadc_enc top: sample mux, -128 clamp, ramp test pattern and the 7-stage digit pipeline.
// Define CADC_ENC_OVR_EN to add the ovr port reporting clamped samples.
module cadc_enc
    import cadc_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic signed [7:0] vin,
    input  logic              vin_vld,
    input  logic              tp_en,
    output dig_t              dig_raw [CADC_NSTAGE]
`ifdef CADC_ENC_OVR_EN
    ,
    output logic              ovr
`endif
);

    logic signed [7:0] r_ramp;
    logic signed [7:0] w_sel;
    logic signed [7:0] w_samp;
    res_t              w_res_chain [CADC_NSTAGE+1];

    // Ramp counter skips -128 so the period is 255 samples.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ramp <= RAMP_MIN;
        end else if (tp_en) begin
            r_ramp <= (r_ramp == RAMP_MAX) ? RAMP_MIN : r_ramp + 8'sd1;
        end else begin
            r_ramp <= r_ramp;
        end
    end

    // Stage 0 sample selection.
    always_comb begin
        w_sel = 8'sd0;
        if (tp_en) begin
            w_sel = r_ramp;
        end else if (vin_vld) begin
            w_sel = vin;
        end else begin
            w_sel = 8'sd0;
        end
    end

    assign w_samp         = (w_sel == SAMPLE_NEG_FS) ? RAMP_MIN : w_sel;
    assign w_res_chain[0] = res_t'(w_samp);

`ifdef CADC_ENC_OVR_EN
    logic w_flag_chain [CADC_NSTAGE+1];

    assign w_flag_chain[0] = !tp_en && (w_sel == SAMPLE_NEG_FS);
    assign ovr             = w_flag_chain[CADC_NSTAGE];
`endif

    for (genvar g = 0; g < CADC_NSTAGE; g++) begin : g_stage
        cadc_enc_stage #(
            .W(stage_weight(g))
        ) u_stage (
            .clk   (clk),
            .rstn  (rstn),
            .i_res (w_res_chain[g]),
`ifdef CADC_ENC_OVR_EN
            .i_flag(w_flag_chain[g]),
            .o_flag(w_flag_chain[g+1]),
`endif
            .o_dig (dig_raw[g]),
            .o_res (w_res_chain[g+1])
        );
    end

endmodule

// File: tb/tb_cadc_enc.sv
// Self-checking bench for cadc_enc: table vectors, ramp, random stream and mid-flight reset,
// checked per stage and by re-summing the de-skewed digits of every sample.
module tb_cadc_enc;

    logic              clk = 1'b0;
    logic              rstn;
    logic signed [7:0] vin;
    logic              vin_vld;
    logic              tp_en;
    logic [1:0]        dig_raw [7];
`ifdef CADC_ENC_OVR_EN
    logic              ovr;
`endif

    cadc_enc dut (
        .clk    (clk),
        .rstn   (rstn),
        .vin    (vin),
        .vin_vld(vin_vld),
        .tp_en  (tp_en),
        .dig_raw(dig_raw)
`ifdef CADC_ENC_OVR_EN
        ,
        .ovr    (ovr)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [7:0] vin;
        logic              vld;
        logic [13:0]       dig;
    } vec_t;

    int          n_vec = 0;
    int          n_err = 0;
    int          ramp_m;
    logic [13:0] sb_dig  [7];
    logic        sb_flag [7];
    int          sb_val  [7];
    int          acc     [7];
    vec_t        tab     [10];

    function automatic int clampv(input int s);
        return (s == -128) ? -127 : s;
    endfunction

    // Reference: digits packed stage 0 in the top two bits.
    function automatic logic [13:0] model_digits(input int s);
        int          r;
        logic [13:0] d;
        r = clampv(s);
        d = 14'b0;
        for (int i = 0; i < 7; i++) begin
            int w;
            w = 1 << (6 - i);
            if (2 * r >= w) begin
                d[13-2*i -: 2] = 2'b01;
                r = r - w;
            end else if (2 * r <= -w) begin
                d[13-2*i -: 2] = 2'b11;
                r = r + w;
            end
        end
        return d;
    endfunction

    function automatic int dec(input logic [1:0] c);
        case (c)
            2'b01:   return 1;
            2'b11:   return -1;
            2'b00:   return 0;
            default: return 1000;
        endcase
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic sb_clear();
        for (int i = 0; i < 7; i++) begin
            sb_dig[i]  = 14'b0;
            sb_flag[i] = 1'b0;
            sb_val[i]  = 0;
            acc[i]     = 0;
        end
    endtask

    task automatic chk_zero(input string nm);
        for (int i = 0; i < 7; i++) chk($sformatf("%s_dig%0d", nm, i), int'(dig_raw[i]), 0);
`ifdef CADC_ENC_OVR_EN
        chk($sformatf("%s_ovr", nm), int'(ovr), 0);
`endif
    endtask

    task automatic step(input logic signed [7:0] v, input logic vld, input logic tp,
                        input logic use_tab, input logic [13:0] tab_dig);
        int s;
        s = tp ? ramp_m : (vld ? int'(v) : 0);
        for (int j = 6; j > 0; j--) begin
            sb_dig[j]  = sb_dig[j-1];
            sb_flag[j] = sb_flag[j-1];
            sb_val[j]  = sb_val[j-1];
            acc[j]     = acc[j-1];
        end
        sb_dig[0]  = use_tab ? tab_dig : model_digits(s);
        sb_flag[0] = (!tp && vld && s == -128);
        sb_val[0]  = clampv(s);
        acc[0]     = 0;
        vin     = v;
        vin_vld = vld;
        tp_en   = tp;
        if (tp) ramp_m = (ramp_m == 127) ? -127 : ramp_m + 1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("dig%0d", i), int'(dig_raw[i]), int'(sb_dig[i][13-2*i -: 2]));
            acc[i] = acc[i] + dec(dig_raw[i]) * (1 << (6 - i));
        end
        chk("dig_out", acc[6], sb_val[6]);
`ifdef CADC_ENC_OVR_EN
        chk("ovr", int'(ovr), int'(sb_flag[6]));
`endif
    endtask

    initial begin
        tab[0] = '{8'sd0,    1'b1, 14'b0};
        tab[1] = '{8'sd100,  1'b1, {2'b01, 2'b01, 2'b00, 2'b01, 2'b11, 2'b00, 2'b00}};
        tab[2] = '{8'sh80,   1'b1, 14'h3FFF};
        tab[3] = '{8'sd127,  1'b1, 14'b01_0101_0101_0101};
        tab[4] = '{-8'sd127, 1'b1, 14'h3FFF};
        tab[5] = '{8'sd0,    1'b1, 14'b0};
        tab[6] = '{8'sd1,    1'b1, {2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b11}};
        tab[7] = '{-8'sd1,   1'b1, {2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b01}};
        tab[8] = '{8'sd50,   1'b1, {2'b01, 2'b00, 2'b11, 2'b00, 2'b01, 2'b11, 2'b00}};
        tab[9] = '{8'sd77,   1'b0, 14'b0};

        rstn    = 1'b0;
        vin     = 8'sd0;
        vin_vld = 1'b0;
        tp_en   = 1'b0;
        ramp_m  = -127;
        sb_clear();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rstn = 1'b1;

        repeat (20) step(8'sd0, 1'b1, 1'b0, 1'b0, 14'b0);

        for (int k = 0; k < 10; k++) step(tab[k].vin, tab[k].vld, 1'b0, 1'b1, tab[k].dig);
        repeat (8) step(8'sd0, 1'b0, 1'b0, 1'b0, 14'b0);

        repeat (510) step(8'sd0, 1'b0, 1'b1, 1'b0, 14'b0);
        chk("ramp_wrap_model", ramp_m, -127);
        repeat (8) step(8'sd0, 1'b0, 1'b0, 1'b0, 14'b0);

        for (int k = 0; k < 400; k++) begin
            step(8'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
                 1'b0, 14'b0);
        end
        repeat (8) step(8'sd0, 1'b0, 1'b0, 1'b0, 14'b0);

        repeat (5) step(8'sd100, 1'b1, 1'b0, 1'b0, 14'b0);
        #2;
        rstn = 1'b0;
        #1;
        chk_zero("rst_async");
        sb_clear();
        ramp_m = -127;
        @(posedge clk);
        #1;
        chk_zero("rst_hold");
        rstn = 1'b1;
        repeat (10) step(8'sd0, 1'b0, 1'b0, 1'b0, 14'b0);
        repeat (3) step(8'sd0, 1'b0, 1'b1, 1'b0, 14'b0);
        repeat (8) step(8'sd0, 1'b0, 1'b0, 1'b0, 14'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
